arb_mux_n: RTL
==============

# arb_mux_n

Registered N-input arbitrating multiplexer with valid/ready handshakes on every input and on the output. It generalises the datapath 3-way select mux to N channels. It selects the source either from an explicit select field (fixed mode) or by round-robin arbitration, and it holds the selected word in a one-stage output register. It sits between multiple producers (forwarding paths, writeback sources, memory response ports) and a single consumer stage of the CPU pipeline.

## Interface
- DATA_WIDTH, 32, width of each data word
- NUM_INPUTS, 3, number of input channels; legal range 2 to 16
- SEL_WIDTH, $clog2(NUM_INPUTS), width of the select field and of `out_src` (derived; not to be overridden)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  1  0 = fixed select, 1 = round-robin
- select  in  SEL_WIDTH  source index used in fixed mode
- in_valid  in  NUM_INPUTS  per-channel valid; bit i belongs to channel i
- in_data  in  NUM_INPUTS*DATA_WIDTH  packed; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_ready  out  NUM_INPUTS  per-channel ready (combinational)
- out_valid  out  1  output register holds a word
- out_data  out  DATA_WIDTH  registered word
- out_src  out  SEL_WIDTH  index of the channel that supplied out_data
- out_ready  in  1  consumer accepts the word

## Operation
- Reset values: out_valid=0, out_data=0, out_src=0, rr_ptr=NUM_INPUTS-1 (so channel 0 has first priority), lock=0.
- Load enable: `load_ok = !out_valid || out_ready`.
- Grant is one-hot and combinational. Fixed mode: grant = channel `select`. A `select` value >= NUM_INPUTS maps to channel NUM_INPUTS-1. Round-robin mode: grant = first channel with in_valid=1, searching from rr_ptr+1 upward with wrap; no valid channel means no grant.
- `in_ready[i] = grant[i] && load_ok`. Ready never depends on in_valid[i] except through the round-robin search. A fixed-mode channel therefore sees ready even while idle.
- Transfer on channel i = in_valid[i] && in_ready[i]. At most one transfer per cycle.
- On transfer: out_data <= word i, out_src <= i, out_valid <= 1. In round-robin mode, rr_ptr <= i.
- No transfer and out_ready=1: out_valid <= 0; out_data and out_src hold their values.
- Simultaneous drain and refill (out_valid=1, out_ready=1, transfer): new word loads with no bubble, and out_valid stays 1.
- Output stalled (out_valid=1, out_ready=0): all in_ready=0, and the register holds.
- A mode or select change takes effect in the same cycle; rr_ptr is not altered by fixed-mode transfers.
- Reset asserted mid-operation clears the register and pointer immediately. An in-flight word is dropped and no transfer is recorded.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word per cycle while out_ready=1.
- in_ready is combinational from mode, select, in_valid, out_valid, out_ready, rr_ptr and lock. There is no combinational path from in_data to any output.
- Round-robin fairness: with all N channels continuously valid and out_ready=1, grants follow 0,1,…,N-1,0,…, one per cycle.

## Configuration
- ARB_MUX_LOCK_EN defined:
  - adds port `in_lock  in  NUM_INPUTS`.
  - A round-robin transfer with in_lock[i]=1 sets lock=1. While lock=1, the grant is forced to rr_ptr regardless of other valids.
  - The first transfer on that channel with in_lock=0 clears lock. Lock is ignored and held cleared in fixed mode.
  - Switching to fixed mode clears lock.
- ARB_MUX_LOCK_EN undefined: port absent, no lock state, and every transfer re-arbitrates.

## Test plan
- Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_src=0 in the same cycle. After release, with all channels valid, the first grant is channel 0.
- Fixed mode, NUM_INPUTS=3, select=2'b11, in_data ch2=32'hC0DE0002 -> one cycle later out_data=32'hC0DE0002, out_src=2.
- Round-robin with all 3 channels valid and out_ready=1 for 6 cycles -> out_src sequence 0,1,2,0,1,2; no idle cycles.
- Back-pressure: out_ready=0 for 4 cycles with out_valid=1 -> in_ready=3'b000, and out_data is stable. Raising out_ready with ch1 valid -> next word loads with no bubble.
- Sparse round-robin: only ch2 valid, then ch0 and ch2 valid -> grants 2, then 0.
- ARB_MUX_LOCK_EN: ch1 sends 3 words with in_lock=1,1,0 while ch0 and ch2 are valid -> out_src=1,1,1, then 2.

Source files
------------

// File: rtl/arb_mux_n.sv
// arb_mux_n: registered N-input arbitrating multiplexer with valid/ready
// handshakes on every input channel and on the output.
// Source is chosen by an explicit select field (mode=0) or by round-robin
// arbitration (mode=1); the chosen word is held in a one-stage output register.
// Optional feature macro: ARB_MUX_LOCK_EN adds in_lock, which lets a
// round-robin winner keep the grant for a multi-word burst.
module arb_mux_n #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_INPUTS = 3,
  // Derived width; leave at its default.
  parameter int unsigned SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             mode,
  input  logic [SEL_WIDTH-1:0]             select,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
`ifdef ARB_MUX_LOCK_EN
  input  logic [NUM_INPUTS-1:0]            in_lock,
`endif
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [SEL_WIDTH-1:0]             out_src,
  input  logic                             out_ready
);

  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_INPUTS - 1);

  // Output register and round-robin pointer (index of the last rr winner).
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [SEL_WIDTH-1:0]  r_out_src;
  logic [SEL_WIDTH-1:0]  r_rr_ptr;

  // Grant and transfer nets.
  logic                  w_load_ok;
  logic [SEL_WIDTH-1:0]  w_fix_idx;
  logic                  w_rr_hit;
  logic [SEL_WIDTH-1:0]  w_rr_idx;
  logic                  w_grant_any;
  logic [SEL_WIDTH-1:0]  w_grant_idx;
  logic                  w_xfer;
  logic [DATA_WIDTH-1:0] w_grant_data;

`ifdef ARB_MUX_LOCK_EN
  typedef enum logic {
    LK_OPEN = 1'b0,
    LK_HELD = 1'b1
  } lock_state_t;

  lock_state_t r_lock;
  lock_state_t w_lock_nxt;
`endif

  // The output register can take a word when empty or being drained.
  assign w_load_ok = !r_out_valid || out_ready;

  // Fixed-mode index: out-of-range select values clamp to the last channel.
  always_comb begin
    w_fix_idx = select;
    if (32'(select) >= NUM_INPUTS) begin
      w_fix_idx = LAST_IDX;
    end
  end

  // Round-robin search: first valid channel after r_rr_ptr, wrapping.
  always_comb begin
    int unsigned          cand;
    logic [SEL_WIDTH-1:0] cidx;
    w_rr_hit = 1'b0;
    w_rr_idx = r_rr_ptr;
    cand     = 0;
    cidx     = '0;
    for (int unsigned k = 1; k <= NUM_INPUTS; k++) begin
      cand = 32'(r_rr_ptr) + k;
      if (cand >= NUM_INPUTS) begin
        cand = cand - NUM_INPUTS;
      end
      cidx = SEL_WIDTH'(cand);
      if (!w_rr_hit && in_valid[cidx]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = cidx;
      end
    end
  end

  // Grant selection by mode; a held lock pins the grant to the last winner.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = w_fix_idx;
    if (!mode) begin
      w_grant_any = 1'b1;
      w_grant_idx = w_fix_idx;
    end
`ifdef ARB_MUX_LOCK_EN
    else if (r_lock == LK_HELD) begin
      w_grant_any = 1'b1;
      w_grant_idx = r_rr_ptr;
    end
`endif
    else begin
      w_grant_any = w_rr_hit;
      w_grant_idx = w_rr_idx;
    end
  end

  // One-hot ready towards the granted channel, gated by output space.
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      in_ready[i] = w_grant_any && w_load_ok && (32'(w_grant_idx) == i);
    end
  end

  // At most one ready bit is set, so this is the single transfer strobe.
  assign w_xfer = |(in_valid & in_ready);

  // Word of the granted channel.
  always_comb begin
    w_grant_data = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (32'(w_grant_idx) == i) begin
        w_grant_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output register: load on transfer, drop valid when drained, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_grant_data;
      r_out_src   <= w_grant_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Round-robin pointer follows round-robin winners only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= LAST_IDX;
    end else if (w_xfer && mode) begin
      r_rr_ptr <= w_grant_idx;
    end
  end

`ifdef ARB_MUX_LOCK_EN
  // Lock state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock <= LK_OPEN;
    end else begin
      r_lock <= w_lock_nxt;
    end
  end

  // Lock next state: a rr transfer takes the transferring channel's lock
  // bit (set on 1, released on 0); fixed mode forces the lock open.
  always_comb begin
    w_lock_nxt = r_lock;
    if (!mode) begin
      w_lock_nxt = LK_OPEN;
    end else if (w_xfer) begin
      w_lock_nxt = in_lock[w_grant_idx] ? LK_HELD : LK_OPEN;
    end
  end
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule
